// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: pops burst_len words and
// streams them out on valid/ready through a 3-entry skid buffer that hides the FIFO read latency.
module fifo_burst_reader #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [LEN_W-1:0]  words_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_t            state_r;
    state_t            state_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  issued_r;
    logic [LEN_W-1:0]  words_out_r;
    logic              inflight_r;
    logic [1:0]        occ_r;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] q0_r;
    logic [DATA_W-1:0] q1_r;
    logic [DATA_W-1:0] q2_r;
    logic [DATA_W-1:0] q0_s;
    logic [DATA_W-1:0] q1_s;
    logic [DATA_W-1:0] q2_s;
    logic              rd_en_s;
    logic              xfer_s;
    logic              start_acc_s;

    // Output decode from registered state; fifo_rd_en is the only combinational path (from fifo_empty).
    assign m_valid    = (occ_r != 2'd0);
    assign m_data     = q0_r;
    assign busy       = (state_r != ST_IDLE);
    assign done       = (state_r == ST_DONE);
    assign words_out  = words_out_r;
    assign fifo_rd_en = rd_en_s;
    assign xfer_s     = m_valid && m_ready;

    // Read credit: a word may be requested only if the skid buffer can hold it along with any in-flight word.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_RUN) && !fifo_empty && (issued_r < len_r) &&
            ((occ_r + {1'b0, inflight_r}) < 2'd3)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state logic for the burst FSM.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = (burst_len == LEN_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s && ((words_out_r + LEN_ONE) == len_r)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Skid queue update: pop shifts toward the head first, then the returning FIFO word lands behind the survivors.
    always_comb begin
        q0_s  = q0_r;
        q1_s  = q1_r;
        q2_s  = q2_r;
        occ_s = occ_r;
        if (xfer_s) begin
            q0_s  = q1_r;
            q1_s  = q2_r;
            occ_s = occ_r - 2'd1;
        end else begin
            occ_s = occ_r;
        end
        if (inflight_r) begin
            case (occ_s)
                2'd0:    q0_s = fifo_data;
                2'd1:    q1_s = fifo_data;
                2'd2:    q2_s = fifo_data;
                default: q2_s = q2_r;
            endcase
            occ_s = occ_s + 2'd1;
        end else begin
            occ_s = occ_s;
        end
    end

    // State, skid buffer and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            q0_r       <= DATA_ZERO;
            q1_r       <= DATA_ZERO;
            q2_r       <= DATA_ZERO;
        end else begin
            state_r    <= state_s;
            occ_r      <= occ_s;
            inflight_r <= rd_en_s;
            q0_r       <= q0_s;
            q1_r       <= q1_s;
            q2_r       <= q2_s;
        end
    end

    // Burst length and counters; words_out keeps the final count after the burst until the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_r       <= LEN_ZERO;
            issued_r    <= LEN_ZERO;
            words_out_r <= LEN_ZERO;
        end else if (start_acc_s) begin
            len_r       <= burst_len;
            issued_r    <= LEN_ZERO;
            words_out_r <= LEN_ZERO;
        end else begin
            if (rd_en_s) begin
                issued_r <= issued_r + LEN_ONE;
            end
            if (xfer_s) begin
                words_out_r <= words_out_r + LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural registered-read FIFO model.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       busy;
    logic       done;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic [7:0] words_out;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       fq_flush = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] got[$];
    int pops = 0;
    int done_cnt = 0;
    int rd_empty_cnt = 0;
    int checks = 0;
    int errors = 0;

    fifo_burst_reader #(.DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .words_out(words_out)
    );

    always #5 clk = ~clk;

    // FIFO model: registered data_out and registered empty flag.
    always @(posedge clk) begin
        if (fq_flush) fq.delete();
        if (fifo_rd_en) begin
            if (fifo_empty) rd_empty_cnt++;
            if (fq.size() > 0) begin
                fifo_data <= fq.pop_front();
                pops++;
            end
        end
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor.
    always @(posedge clk) begin
        if (m_valid && m_ready) got.push_back(m_data);
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        wr_en = 1'b1;
        wr_data = w;
        step();
        wr_en = 1'b0;
    endtask

    task automatic preload(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) push_word(first + 8'(i));
    endtask

    task automatic flush();
        fq_flush = 1'b1;
        step();
        fq_flush = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        check_bit("done_seen", done, 1'b1);
    endtask

    task automatic check_stream(input string tag, input int base, input logic [7:0] first, input int n);
        logic [7:0] v;
        check_int({tag, "_count"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            v = (base + i < got.size()) ? got[base + i] : 8'hxx;
            check_byte($sformatf("%s[%0d]", tag, i), v, first + 8'(i));
        end
    endtask

    initial begin
        logic [7:0] exp1 [4];
        logic [7:0] e_rd;
        logic [7:0] e_val;
        logic [7:0] e_done;
        logic [7:0] e_busy;
        int pb, gb, db, eb, k;

        // Reset state
        step();
        step();
        check_bit("rst_rd_en", fifo_rd_en, 1'b0);
        check_bit("rst_m_valid", m_valid, 1'b0);
        check_byte("rst_m_data", m_data, 8'h00);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_byte("rst_words_out", words_out, 8'h00);
        reset = 1'b1;
        step();

        // Burst of 4 with back-to-back reads and 1 word/cycle output
        exp1[0] = 8'hA1; exp1[1] = 8'hB2; exp1[2] = 8'hC3; exp1[3] = 8'hC4;
        for (int i = 0; i < 4; i++) push_word(exp1[i]);
        e_rd = 8'b1111_0000; e_val = 8'b0011_1100; e_done = 8'b0000_0010; e_busy = 8'b1111_1110;
        pb = pops; gb = got.size();
        m_ready = 1'b1; start = 1'b1; burst_len = 8'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_bit($sformatf("t1_rd_en[%0d]", i), fifo_rd_en, e_rd[7-i]);
            check_bit($sformatf("t1_m_valid[%0d]", i), m_valid, e_val[7-i]);
            check_bit($sformatf("t1_done[%0d]", i), done, e_done[7-i]);
            check_bit($sformatf("t1_busy[%0d]", i), busy, e_busy[7-i]);
            if (e_val[7-i]) begin
                k = i - 2;
                check_byte($sformatf("t1_m_data[%0d]", i), m_data, exp1[k]);
            end
            step();
        end
        check_byte("t1_words_out", words_out, 8'd4);
        check_int("t1_pops", pops - pb, 4);
        check_int("t1_stream_count", got.size() - gb, 4);

        // burst_len=3 with 6 words queued
        preload(8'h10, 6);
        pb = pops; gb = got.size();
        start = 1'b1; burst_len = 8'd3;
        step();
        start = 1'b0;
        step(); step(); step();
        check_bit("t2_rd_en_after_3", fifo_rd_en, 1'b0);
        wait_done(20);
        check_bit("t2_busy_at_done", busy, 1'b1);
        step();
        check_bit("t2_busy_after", busy, 1'b0);
        check_bit("t2_done_after", done, 1'b0);
        check_int("t2_pops", pops - pb, 3);
        check_int("t2_fifo_left", fq.size(), 3);
        check_byte("t2_words_out", words_out, 8'd3);
        check_stream("t2_stream", gb, 8'h10, 3);

        // Downstream stall during burst_len=8; a start during RUN is ignored
        flush();
        preload(8'h30, 8);
        pb = pops; gb = got.size();
        m_ready = 1'b0; start = 1'b1; burst_len = 8'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            burst_len = (i == 4) ? 8'd2 : 8'd8;
            step();
        end
        start = 1'b0;
        check_int("t3_pops_stalled", pops - pb, 3);
        check_bit("t3_rd_en_stalled", fifo_rd_en, 1'b0);
        check_bit("t3_m_valid_stalled", m_valid, 1'b1);
        check_byte("t3_m_data_frozen", m_data, 8'h30);
        check_byte("t3_words_out_stalled", words_out, 8'd0);
        m_ready = 1'b1;
        wait_done(40);
        check_byte("t3_words_out", words_out, 8'd8);
        check_int("t3_pops", pops - pb, 8);
        check_stream("t3_stream", gb, 8'h30, 8);
        step();

        // FIFO initially empty; words trickle in
        pb = pops; gb = got.size(); db = done_cnt; eb = rd_empty_cnt;
        start = 1'b1; burst_len = 8'd2;
        step();
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i <= 4) check_bit($sformatf("t4_rd_en_empty[%0d]", i), fifo_rd_en, 1'b0);
            wr_en = (i == 4) || (i == 8);
            wr_data = (i == 4) ? 8'h11 : 8'h22;
            step();
        end
        wr_en = 1'b0;
        check_int("t4_done_pulses", done_cnt - db, 1);
        check_int("t4_rd_while_empty", rd_empty_cnt - eb, 0);
        check_int("t4_pops", pops - pb, 2);
        check_int("t4_stream_count", got.size() - gb, 2);
        check_byte("t4_word0", (gb < got.size()) ? got[gb] : 8'hxx, 8'h11);
        check_byte("t4_word1", (gb + 1 < got.size()) ? got[gb + 1] : 8'hxx, 8'h22);
        check_byte("t4_words_out", words_out, 8'd2);
        check_bit("t4_busy", busy, 1'b0);

        // Zero-length burst; start during DONE is ignored
        pb = pops; db = done_cnt;
        start = 1'b1; burst_len = 8'd0;
        step();
        check_bit("t5_done", done, 1'b1);
        check_bit("t5_busy", busy, 1'b1);
        check_bit("t5_rd_en", fifo_rd_en, 1'b0);
        check_byte("t5_words_out", words_out, 8'd0);
        burst_len = 8'd5;
        step();
        start = 1'b0;
        check_bit("t5_done_end", done, 1'b0);
        check_bit("t5_busy_end", busy, 1'b0);
        step();
        check_bit("t5_busy_ignored", busy, 1'b0);
        check_byte("t5_words_out_ignored", words_out, 8'd0);
        check_int("t5_done_pulses", done_cnt - db, 1);
        check_int("t5_pops", pops - pb, 0);

        // Reset mid-burst, then a fresh burst
        preload(8'h50, 5);
        db = done_cnt;
        start = 1'b1; burst_len = 8'd5;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        check_byte("t6_words_before", words_out, 8'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_bit("t6_m_valid", m_valid, 1'b0);
        check_bit("t6_rd_en", fifo_rd_en, 1'b0);
        check_bit("t6_busy", busy, 1'b0);
        check_byte("t6_words_out", words_out, 8'd0);
        check_bit("t6_done", done, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check_int("t6_no_done", done_cnt - db, 0);
        check_bit("t6_m_valid_idle", m_valid, 1'b0);
        flush();
        preload(8'h60, 2);
        gb = got.size();
        start = 1'b1; burst_len = 8'd2;
        step();
        start = 1'b0;
        wait_done(20);
        check_byte("t6_words_out_new", words_out, 8'd2);
        check_stream("t6_stream", gb, 8'h60, 2);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's synchronous FIFO (fifo: clk, reset, write_en, read_en, data_in, full, empty, data_out).
- On a start command, pops exactly burst_len words from the FIFO and presents them on a valid/ready stream.
- Absorbs the FIFO's one-cycle registered read latency with an internal 3-entry skid buffer, so there is no overrun and no combinational ready-to-read_en path.

Parameters:
DATA_W, 8, FIFO and stream data width
LEN_W, 8, width of burst_len and words_out

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low; reset=0 at a rising clk edge resets the block
start  input  1  one-cycle burst request, sampled only in IDLE
burst_len  input  LEN_W  number of words to read, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when the last word of the burst is accepted downstream
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_W  FIFO data_out, valid the cycle after fifo_rd_en
fifo_rd_en  output  1  FIFO read_en
m_valid  output  1  stream data valid
m_data  output  DATA_W  stream data
m_ready  input  1  downstream accept
words_out  output  LEN_W  words accepted downstream in the current/last burst

Behaviour:
- Reset values: state=IDLE; fifo_rd_en=0; m_valid=0; m_data=0; busy=0; done=0; words_out=0; skid occupancy=0; inflight=0; issued count=0.
- Reset mid-burst aborts the burst.
  - Buffered and in-flight words are discarded (already popped from the FIFO, so lost).
  - done is not pulsed.
- State machine:
  - IDLE: on start=1, latch len_r=burst_len, clear words_out and issued.
    - If burst_len=0, go to DONE.
    - Otherwise go to RUN.
  - RUN: go to DONE in the cycle after the transfer that makes words_out==len_r.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- fifo_rd_en (combinational from registers and fifo_empty) = RUN && !fifo_empty && issued<len_r && (occ+inflight)<3.
  - Independent of m_ready.
  - Never asserted while fifo_empty=1.
- Each fifo_rd_en cycle: issued++ and inflight<=1. The next cycle, fifo_data is written into the skid buffer and inflight<=0.
- Skid buffer:
  - 3-entry in-order queue; never overflows, guaranteed by the credit rule.
  - m_valid = occ>0; m_data = head entry.
  - Head is registered; m_data is held stable while m_valid && !m_ready.
- Transfer = m_valid && m_ready; each transfer does words_out++.
  - Push and pop in the same cycle keep occ unchanged, with order preserved.
- Latency: rd_en in cycle N -> fifo_data in N+1 -> m_valid at N+2 (buffer empty case).
  - From start in IDLE to first m_valid: 3 cycles minimum (start N, RUN N+1, rd_en N+1, m_valid N+3).
- Throughput: 1 word/cycle sustained with m_ready=1 and FIFO non-empty.
- FIFO empties mid-burst: reads pause and resume automatically when fifo_empty falls. The burst length is never shortened.
- Downstream stall: at most 3 words are popped beyond those accepted; then fifo_rd_en stays low.
- Counters:
  - issued and words_out never exceed len_r.
  - No wrap within a burst; len_r max 2^LEN_W-1.
- After done, words_out holds the final count until the next accepted start.

Test Plan:
- Reset, then FIFO preloaded with A1,B2,C3,C4; start with burst_len=4 and m_ready=1 -> fifo_rd_en high 4 consecutive cycles; m_data A1,B2,C3,C4 on 4 consecutive cycles; done pulse 1 cycle after the C4 transfer; words_out=4; exactly 4 FIFO pops.
- burst_len=3 with FIFO holding 6 words -> exactly 3 pops; FIFO retains 3 words; fifo_rd_en low after the 3rd issue; busy falls after done.
- m_ready=0 for 10 cycles during burst_len=8 -> exactly 3 words popped, then fifo_rd_en=0; m_data frozen at the first word; after m_ready=1, all 8 words arrive in order with no loss or duplication.
- FIFO initially empty, start burst_len=2, write 11 at cycle +5 and 22 at cycle +9 -> fifo_rd_en asserted only while not empty; output 11,22; done pulse; no reads while empty.
- start with burst_len=0 -> no fifo_rd_en; done pulse on the 2nd cycle after start; words_out=0. A start pulse during busy is ignored (words_out is unaffected).
- reset=0 for one cycle mid-burst (after 2 of 5 words accepted) -> next cycle: m_valid=0, fifo_rd_en=0, busy=0, words_out=0, done never pulses; a new start then works normally.
